// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (adds the trailing checksum word).
package imem_loader_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned HDR_BYTES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    // States in which the loader is consuming stream bytes.
    function automatic logic is_busy(input state_e s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

    // States in which a start request opens a new session.
    function automatic logic can_start(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by header, data and checksum words.
// The completed word and its strobe are presented combinationally in the cycle
// the last byte is accepted so the controller can act on it without a bubble.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned NBYTES = WORD_BYTES
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     byte_valid_i,
    input  logic [BYTE_W-1:0]        byte_i,
    output logic [NBYTES*BYTE_W-1:0] word_c,
    output logic                     word_valid_c
);

    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned PACK_W = NBYTES * BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [PACK_W-1:0] shreg_q, shreg_d;
    logic [PACK_W-1:0] assembled;

    // Merge the incoming byte into its lane and advance the byte index.
    always_comb begin
        assembled = shreg_q;
        assembled[32'(idx_q) * BYTE_W +: BYTE_W] = byte_i;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (byte_valid_i) begin
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            shreg_d = assembled;
        end
    end

    // Byte index and partial-word storage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_c       = assembled;
    assign word_valid_c = byte_valid_i && (idx_q == LAST_IDX) && !clear_i;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length header, packed data words,
// sequential writes from address 0, and fetch-unit reset release when complete.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (verifies a trailing sum word).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W      = ADDR_W + 1;
    localparam int unsigned PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e END_STATE = ST_CHK;
`else
    localparam state_e END_STATE = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
`endif

    logic              accept_c;
    logic              pk_clear_c;
    logic [WORD_W-1:0] pk_word_c;
    logic              pk_word_valid_c;

    assign accept_c = in_valid && in_ready_q;

    imem_loader_byte_packer #(
        .NBYTES (PACK_BYTES)
    ) u_byte_packer (
        .clk_i        (CLK),
        .reset_i      (reset),
        .clear_i      (pk_clear_c),
        .byte_valid_i (accept_c),
        .byte_i       (in_byte),
        .word_c       (pk_word_c),
        .word_valid_c (pk_word_valid_c)
    );

    // Next-state, write scheduling and registered status outputs.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pk_clear_c   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        // A write issued this cycle is counted at the end of it.
        if (mem_we_q) begin
            word_count_d = word_count_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_HDR;
                    word_count_d = '0;
                    pk_clear_c   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end
            ST_HDR: begin
                if (pk_word_valid_c) begin
                    n_d = pk_word_c[ADDR_W:0];
                    if (pk_word_c == '0) begin
                        state_d = END_STATE;
                    end else if (pk_word_c > WORD_W'(DEPTH)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // At most one word completes per four cycles, so word_count_q
                // already reflects every earlier word here.
                if (pk_word_valid_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_count_q[ADDR_W-1:0];
                    mem_wdata_d = pk_word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + pk_word_c;
`endif
                    if ((word_count_q + CNT_W'(1)) == n_q) begin
                        state_d = END_STATE;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (pk_word_valid_c) begin
                    state_d = (pk_word_c == sum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = is_busy(state_d);
        busy_d      = is_busy(state_d);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            word_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as the
// stimulus is sent and matched against every mem_we pulse.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (sends/tests checksum words).
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              CLK = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_wr;
    int          checks   = 0;
    int          passed   = 0;
    int          n_writes = 0;
    logic [31:0] sum;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (mem_we === 1'b1) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                exp_wr = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp_wr) begin
                    $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, exp_wr.addr, exp_wr.data);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic begin_session();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        sum   = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            cyc(1);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL byte_accept_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_data(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_q.push_back('{addr: a, data: w});
        sum = sum + w;
        send_word(w);
    endtask

    task automatic send_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum);
`endif
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < budget) begin
            cyc(1);
            k++;
        end
        checks++;
        if (k >= budget) $display("FAIL end_timeout: done=%b error=%b after %0d cycles, required done or error", done, error, k);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        cyc(2);
        checks++;
        if ({in_ready, mem_we, busy, done, error, cpu_reset} !== 6'b000001)
            $display("FAIL reset_flags: got rdy/we/busy/done/err/cpurst=%b, required 000001",
                     {in_ready, mem_we, busy, done, error, cpu_reset});
        else passed++;
        checks++;
        if ({mem_addr, mem_wdata, word_count} !== '0)
            $display("FAIL reset_values: got addr=%h wdata=%h count=%0d, required all zero", mem_addr, mem_wdata, word_count);
        else passed++;
        reset = 1'b0;
        in_valid = 1'b1; in_byte = 8'h5A;
        cyc(2);
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, cpu_reset} !== 3'b001)
            $display("FAIL idle_hold: got rdy/busy/cpurst=%b, required 001", {in_ready, busy, cpu_reset});
        else passed++;
    endtask

    task automatic test_basic();
        begin_session();
        checks++;
        if ({busy, in_ready, cpu_reset, done} !== 4'b1110)
            $display("FAIL hdr_entry: got busy/rdy/cpurst/done=%b, required 1110", {busy, in_ready, cpu_reset, done});
        else passed++;
        send_word(32'd2);
        send_data(8'd0, 32'h1234_5678);
        send_data(8'd1, 32'hDEAD_BEEF);
        send_checksum();
        wait_end(20);
        cyc(1);
        checks++;
        if ({done, error, cpu_reset, in_ready, busy} !== 5'b10000)
            $display("FAIL basic_done: got done/err/cpurst/rdy/busy=%b, required 10000",
                     {done, error, cpu_reset, in_ready, busy});
        else passed++;
        checks++;
        if (word_count !== 9'd2) $display("FAIL basic_count: got %0d, required 2", word_count);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL basic_drain: got %0d pending writes, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_zero_len();
        int w0;
        w0 = n_writes;
        begin_session();
        send_word(32'd0);
        send_checksum();
        wait_end(20);
        cyc(2);
        checks++;
        if ({done, error, cpu_reset} !== 3'b100 || word_count !== 9'd0)
            $display("FAIL zero_len: got done/err/cpurst=%b count=%0d, required 100 count=0",
                     {done, error, cpu_reset}, word_count);
        else passed++;
        checks++;
        if (n_writes != w0) $display("FAIL zero_len_writes: got %0d writes, required 0", n_writes - w0);
        else passed++;
    endtask

    task automatic test_oversize();
        int w0;
        w0 = n_writes;
        begin_session();
        send_word(32'h0000_0101);
        wait_end(20);
        cyc(1);
        checks++;
        if ({error, cpu_reset, done, busy, in_ready} !== 5'b11000)
            $display("FAIL oversize_err: got err/cpurst/done/busy/rdy=%b, required 11000",
                     {error, cpu_reset, done, busy, in_ready});
        else passed++;
        begin_session();
        checks++;
        if ({busy, in_ready, error} !== 3'b110)
            $display("FAIL err_restart: got busy/rdy/err=%b, required 110", {busy, in_ready, error});
        else passed++;
        // Low bits zero but upper bits set must still be rejected.
        send_word(32'h0001_0000);
        wait_end(20);
        checks++;
        if ({error, done} !== 2'b10) $display("FAIL upper_bits: got err/done=%b, required 10", {error, done});
        else passed++;
        checks++;
        if (n_writes != w0) $display("FAIL oversize_writes: got %0d writes, required 0", n_writes - w0);
        else passed++;
    endtask

    task automatic test_start_with_byte();
        // In ERROR: start and a valid byte together; the byte must be dropped.
        start = 1'b1; in_valid = 1'b1; in_byte = 8'h77;
        cyc(1);
        start = 1'b0; in_valid = 1'b0;
        sum = '0;
        send_word(32'd1);
        send_data(8'd0, 32'h0102_0304);
        send_checksum();
        wait_end(20);
        cyc(1);
        checks++;
        if ({done, error} !== 2'b10 || word_count !== 9'd1)
            $display("FAIL start_byte: got done/err=%b count=%0d, required 10 count=1", {done, error}, word_count);
        else passed++;
    endtask

    task automatic test_stall();
        int w0;
        logic [31:0] w;
        w0 = n_writes;
        w  = 32'hCAFE_F00D;
        begin_session();
        send_word(32'd1);
        exp_q.push_back('{addr: 8'd0, data: w});
        sum = sum + w;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i < 3) begin
                // Gap with garbage on the bus and a start request that must be ignored.
                in_byte = 8'hFF;
                start   = 1'b1;
                cyc(2);
                start   = 1'b0;
            end
        end
        send_checksum();
        wait_end(20);
        cyc(1);
        checks++;
        if (n_writes - w0 != 1) $display("FAIL stall_writes: got %0d writes, required 1", n_writes - w0);
        else passed++;
        checks++;
        if ({done, error} !== 2'b10 || word_count !== 9'd1)
            $display("FAIL stall_done: got done/err=%b count=%0d, required 10 count=1", {done, error}, word_count);
        else passed++;
    endtask

    task automatic test_mid_reset();
        begin_session();
        send_word(32'd2);
        send_data(8'd0, 32'h4433_2211);
        send_byte(8'h55);
        reset = 1'b1;
        cyc(1);
        checks++;
        if ({in_ready, mem_we, busy, done, error, cpu_reset} !== 6'b000001 ||
            {mem_addr, mem_wdata, word_count} !== '0)
            $display("FAIL mid_reset: got flags=%b addr=%h wdata=%h count=%0d, required 000001 and zeros",
                     {in_ready, mem_we, busy, done, error, cpu_reset}, mem_addr, mem_wdata, word_count);
        else passed++;
        reset = 1'b0;
        cyc(1);
        begin_session();
        send_word(32'd1);
        send_data(8'd0, 32'hA5A5_A5A5);
        send_checksum();
        wait_end(20);
        cyc(1);
        checks++;
        if ({done, cpu_reset} !== 2'b10 || word_count !== 9'd1)
            $display("FAIL reload: got done/cpurst=%b count=%0d, required 10 count=1", {done, cpu_reset}, word_count);
        else passed++;
    endtask

    task automatic test_full_depth();
        begin_session();
        send_word(32'(DEPTH));
        for (int i = 0; i < int'(DEPTH); i++) send_data(8'(i), $urandom);
        send_checksum();
        wait_end(40);
        cyc(1);
        checks++;
        if ({done, error} !== 2'b10 || word_count !== 9'(DEPTH))
            $display("FAIL full_depth: got done/err=%b count=%0d, required 10 count=%0d", {done, error}, word_count, DEPTH);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL full_drain: got %0d pending writes, required 0", exp_q.size());
        else passed++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0;
        for (int pass = 0; pass < 2; pass++) begin
            w0 = n_writes;
            begin_session();
            send_word(32'd2);
            send_data(8'd0, 32'h0000_0001);
            send_data(8'd1, 32'h0000_0002);
            send_word((pass == 0) ? 32'd3 : 32'd4);
            wait_end(20);
            cyc(1);
            checks++;
            if ({done, error} !== ((pass == 0) ? 2'b10 : 2'b01))
                $display("FAIL checksum_result%0d: got done/err=%b, required %b", pass, {done, error},
                         (pass == 0) ? 2'b10 : 2'b01);
            else passed++;
            checks++;
            if (n_writes - w0 != 2) $display("FAIL checksum_writes%0d: got %0d writes, required 2", pass, n_writes - w0);
            else passed++;
        end
    endtask
`endif

    initial begin
        sum = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_oversize();
        test_start_with_byte();
        test_stall();
        test_mid_reset();
        test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        cyc(3);
        checks++;
        if (exp_q.size() != 0) $display("FAIL final_drain: got %0d pending writes, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
